// File: rtl/mem_stage_if.sv
// Signal bundle between the MEM stage, the EX/MEM and MEM/WB registers and the byte-serial memory.
interface mem_stage_if #(
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 5
);
  logic                 valid_in;
  logic                 rdE_in;
  logic [REG_IDX_W-1:0] rdIdx_in;
  logic [31:0]          rdData_in;
  logic [3:0]           memOp_in;
  logic [31:0]          storeData_in;
  logic [ADDR_W-1:0]    memAddr_out;
  logic                 memWr_out;
  logic [7:0]           memWData_out;
  logic [7:0]           memRData_in;
  logic                 valid_out;
  logic                 rdE_out;
  logic [REG_IDX_W-1:0] rdIdx_out;
  logic [31:0]          rdData_out;
  logic                 stall_out;

  modport slave (
    input  valid_in, rdE_in, rdIdx_in, rdData_in, memOp_in, storeData_in, memRData_in,
    output memAddr_out, memWr_out, memWData_out,
    output valid_out, rdE_out, rdIdx_out, rdData_out, stall_out
  );

  modport master (
    output valid_in, rdE_in, rdIdx_in, rdData_in, memOp_in, storeData_in, memRData_in,
    input  memAddr_out, memWr_out, memWData_out,
    input  valid_out, rdE_out, rdIdx_out, rdData_out, stall_out
  );
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM stage: passes ALU results through and runs loads/stores one byte per cycle,
// stalling the upstream pipeline until the access completes.
module mem_stage #(
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic clk_in,
  input  logic rst_in,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, LAST, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;

  function automatic logic isMem(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic logic isStore(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic [2:0] lastCnt(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd0;
      OP_LH, OP_LHU, OP_SH: return 3'd1;
      default:              return 3'd3;
    endcase
  endfunction

  state_t               state_q;
  logic [2:0]           cnt_q;
  logic [3:0]           op_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [31:0]          sdata_q;
  logic [31:0]          buf_q;
  logic [REG_IDX_W-1:0] rdIdx_q;
  logic                 rdE_q;
  logic                 validOut_q;
  logic                 rdEOut_q;
  logic [REG_IDX_W-1:0] rdIdxOut_q;
  logic [31:0]          rdDataOut_q;

  logic                 reqMem;
  logic                 stall_d;
  logic [ADDR_W-1:0]    memAddr_d;
  logic                 memWr_d;
  logic [7:0]           memWData_d;
  logic [1:0]           capIdx;
  logic [31:0]          buf_d;
  logic [31:0]          load_d;

  always_comb begin
    reqMem     = bus.valid_in && isMem(bus.memOp_in);
    stall_d    = 1'b0;
    memAddr_d  = '0;
    memWr_d    = 1'b0;
    memWData_d = '0;
    case (state_q)
      IDLE:   stall_d = reqMem;
      ACCESS: begin
        stall_d   = 1'b1;
        memAddr_d = addr_q + ADDR_W'(cnt_q);
        if (isStore(op_q)) begin
          memWr_d    = 1'b1;
          memWData_d = sdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
      end
      LAST:    stall_d = 1'b1;
      default: stall_d = 1'b0;
    endcase
  end

  // Read data lags its address by one cycle, so the byte arriving now belongs to counter-1.
  always_comb begin
    capIdx = cnt_q[1:0] - 2'd1;
    buf_d  = buf_q;
    buf_d[{capIdx, 3'b000} +: 8] = bus.memRData_in;
    case (op_q)
      OP_LB:   load_d = {{24{buf_d[7]}}, buf_d[7:0]};
      OP_LH:   load_d = {{16{buf_d[15]}}, buf_d[15:0]};
      OP_LBU:  load_d = {24'h0, buf_d[7:0]};
      OP_LHU:  load_d = {16'h0, buf_d[15:0]};
      default: load_d = buf_d;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      buf_q       <= '0;
      rdIdx_q     <= '0;
      rdE_q       <= 1'b0;
      validOut_q  <= 1'b0;
      rdEOut_q    <= 1'b0;
      rdIdxOut_q  <= '0;
      rdDataOut_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqMem) begin
            op_q       <= bus.memOp_in;
            addr_q     <= bus.rdData_in[ADDR_W-1:0];
            sdata_q    <= bus.storeData_in;
            rdIdx_q    <= bus.rdIdx_in;
            rdE_q      <= bus.rdE_in;
            cnt_q      <= '0;
            buf_q      <= '0;
            validOut_q <= 1'b0;
            rdEOut_q   <= 1'b0;
            state_q    <= ACCESS;
          end else if (bus.valid_in) begin
            validOut_q  <= 1'b1;
            rdEOut_q    <= bus.rdE_in;
            rdIdxOut_q  <= bus.rdIdx_in;
            rdDataOut_q <= bus.rdData_in;
          end else begin
            validOut_q <= 1'b0;
            rdEOut_q   <= 1'b0;
          end
        end
        ACCESS: begin
          if ((cnt_q != 3'd0) && !isStore(op_q)) buf_q <= buf_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == lastCnt(op_q)) begin
            if (isStore(op_q)) begin
              validOut_q  <= 1'b1;
              rdEOut_q    <= 1'b0;
              rdIdxOut_q  <= rdIdx_q;
              rdDataOut_q <= 32'(addr_q);
              state_q     <= DONE;
            end else begin
              state_q <= LAST;
            end
          end
        end
        LAST: begin
          buf_q       <= buf_d;
          validOut_q  <= 1'b1;
          rdEOut_q    <= rdE_q;
          rdIdxOut_q  <= rdIdx_q;
          rdDataOut_q <= load_d;
          state_q     <= DONE;
        end
        default: begin
          validOut_q <= 1'b0;
          rdEOut_q   <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Stall is forced low during reset even if EX/MEM still presents a memory op.
  assign bus.stall_out    = stall_d & rst_in;
  assign bus.memAddr_out  = memAddr_d;
  assign bus.memWr_out    = memWr_d;
  assign bus.memWData_out = memWData_d;
  assign bus.valid_out    = validOut_q;
  assign bus.rdE_out      = rdEOut_q;
  assign bus.rdIdx_out    = rdIdxOut_q;
  assign bus.rdData_out   = rdDataOut_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset corner case, and random ops
// checked against a cycle-budget and byte-array reference model.
module tb_mem_stage;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  mem_stage_if #(.ADDR_W(32), .REG_IDX_W(5)) bus ();

  mem_stage #(.ADDR_W(32), .REG_IDX_W(5)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  idx;
    logic        rdE;
    logic [31:0] exp;
  } vec_t;

  logic [7:0] tbMem [0:4095];
  vec_t       vecs [8];
  int         vectors = 0;
  int         miscompares = 0;

  function automatic int nBytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  // Little-endian assembly with arithmetic sign extension for LB/LH.
  function automatic logic [31:0] refLoad(input logic [3:0] op, input logic [31:0] addr);
    int          n;
    longint      v;
    logic [31:0] a;
    n = nBytes(op);
    v = 0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      v += longint'(tbMem[a[11:0]]) << (8 * i);
    end
    if ((op == 4'd1 || op == 4'd2) && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advances one clock while acting as the byte memory: read data appears one cycle after its address.
  task automatic step();
    logic [31:0] a;
    logic        w;
    logic [7:0]  d;
    a = bus.memAddr_out;
    w = bus.memWr_out;
    d = bus.memWData_out;
    @(posedge clk_in);
    #1;
    if (w) tbMem[a[11:0]] = d;
    bus.memRData_in = tbMem[a[11:0]];
  endtask

  task automatic idleCycle();
    bus.valid_in = 1'b0;
    step();
    checkOutput("idle valid_out", 32'(bus.valid_out), 32'd0);
    checkOutput("idle rdE_out", 32'(bus.rdE_out), 32'd0);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] idx, input logic rdE, input logic [31:0] exp);
    int   n;
    int   lat;
    logic isLd;
    logic isSt;
    logic [31:0] expPort;
    logic [31:0] a;
    n    = nBytes(op);
    isLd = (op >= 4'd1) && (op <= 4'd5);
    isSt = (op >= 4'd6) && (op <= 4'd8);
    bus.valid_in     = 1'b1;
    bus.memOp_in     = op;
    bus.rdData_in    = addr;
    bus.storeData_in = sdata;
    bus.rdIdx_in     = idx;
    bus.rdE_in       = rdE;
    #1;
    checkOutput($sformatf("stall op%0d k=0", op), 32'(bus.stall_out), 32'(n > 0));
    if (n == 0) begin
      step();
      checkOutput("none valid_out", 32'(bus.valid_out), 32'd1);
      checkOutput("none rdE_out", 32'(bus.rdE_out), 32'(rdE));
      checkOutput("none rdIdx_out", 32'(bus.rdIdx_out), 32'(idx));
      checkOutput("none rdData_out", bus.rdData_out, exp);
      bus.valid_in = 1'b0;
      return;
    end
    lat = isLd ? n + 2 : n + 1;
    for (int k = 1; k <= lat; k++) begin
      step();
      checkOutput($sformatf("stall op%0d k=%0d", op, k), 32'(bus.stall_out), 32'(k < lat));
      if (k <= n) begin
        a = addr + 32'(k - 1);
        checkOutput($sformatf("memAddr op%0d k=%0d", op, k), bus.memAddr_out, a);
        expPort = isSt ? {23'd0, 1'b1, 8'((sdata >> (8 * (k - 1))) & 32'hFF)} : 32'd0;
      end else begin
        checkOutput($sformatf("memAddr idle op%0d k=%0d", op, k), bus.memAddr_out, 32'd0);
        expPort = 32'd0;
      end
      checkOutput($sformatf("memWr/WData op%0d k=%0d", op, k),
                  {23'd0, bus.memWr_out, bus.memWData_out}, expPort);
      checkOutput($sformatf("valid_out op%0d k=%0d", op, k), 32'(bus.valid_out), 32'(k == lat));
    end
    checkOutput($sformatf("rdE_out op%0d", op), 32'(bus.rdE_out), 32'(isLd & rdE));
    checkOutput($sformatf("rdIdx_out op%0d", op), 32'(bus.rdIdx_out), 32'(idx));
    checkOutput($sformatf("rdData_out op%0d", op), bus.rdData_out, exp);
    step();
    checkOutput($sformatf("no duplicate op%0d", op), 32'(bus.valid_out), 32'd0);
    bus.valid_in = 1'b0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] exp;

    rst_in           = 1'b0;
    bus.valid_in     = 1'b0;
    bus.rdE_in       = 1'b0;
    bus.rdIdx_in     = '0;
    bus.rdData_in    = '0;
    bus.memOp_in     = '0;
    bus.storeData_in = '0;
    bus.memRData_in  = '0;
    for (int i = 0; i < 4096; i++) tbMem[i] = 8'($urandom);
    tbMem[12'h200] = 8'h80;
    tbMem[12'h300] = 8'h34;
    tbMem[12'h301] = 8'h92;
    tbMem[12'hFFE] = 8'h11;
    tbMem[12'hFFF] = 8'h22;
    tbMem[12'h000] = 8'h33;
    tbMem[12'h001] = 8'h44;

    #3;
    checkOutput("reset valid_out", 32'(bus.valid_out), 32'd0);
    checkOutput("reset rdE/rdIdx", {26'd0, bus.rdE_out, bus.rdIdx_out}, 32'd0);
    checkOutput("reset rdData_out", bus.rdData_out, 32'd0);
    checkOutput("reset stall/memWr", {30'd0, bus.stall_out, bus.memWr_out}, 32'd0);
    checkOutput("reset memAddr", bus.memAddr_out, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    vecs[0] = '{4'd0,  32'h0000_0123, 32'h0,         5'd5,  1'b1, 32'h0000_0123};
    vecs[1] = '{4'd8,  32'h0000_0100, 32'hDEAD_BEEF, 5'd6,  1'b1, 32'h0000_0100};
    vecs[2] = '{4'd1,  32'h0000_0200, 32'h0,         5'd7,  1'b1, 32'hFFFF_FF80};
    vecs[3] = '{4'd4,  32'h0000_0200, 32'h0,         5'd8,  1'b1, 32'h0000_0080};
    vecs[4] = '{4'd3,  32'hFFFF_FFFE, 32'h0,         5'd9,  1'b1, 32'h4433_2211};
    vecs[5] = '{4'd2,  32'h0000_0300, 32'h0,         5'd10, 1'b1, 32'hFFFF_9234};
    vecs[6] = '{4'd0,  32'h0000_55AA, 32'h0,         5'd11, 1'b0, 32'h0000_55AA};
    vecs[7] = '{4'd12, 32'h0000_0077, 32'h1234_5678, 5'd12, 1'b1, 32'h0000_0077};
    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].idx, vecs[i].rdE, vecs[i].exp);

    checkOutput("SW byte 0x100", 32'(tbMem[12'h100]), 32'hEF);
    checkOutput("SW byte 0x101", 32'(tbMem[12'h101]), 32'hBE);
    checkOutput("SW byte 0x102", 32'(tbMem[12'h102]), 32'hAD);
    checkOutput("SW byte 0x103", 32'(tbMem[12'h103]), 32'hDE);

    // Reset lands in the middle of a LW, with EX/MEM still presenting it.
    bus.valid_in  = 1'b1;
    bus.memOp_in  = 4'd3;
    bus.rdData_in = 32'h0000_0400;
    bus.rdIdx_in  = 5'd3;
    bus.rdE_in    = 1'b1;
    step();
    step();
    step();
    checkOutput("midLW memAddr", bus.memAddr_out, 32'h0000_0402);
    rst_in = 1'b0;
    #1;
    checkOutput("async reset stall", 32'(bus.stall_out), 32'd0);
    checkOutput("async reset memAddr", bus.memAddr_out, 32'd0);
    checkOutput("async reset memWr/WData", {23'd0, bus.memWr_out, bus.memWData_out}, 32'd0);
    checkOutput("async reset valid/rdE/rdIdx", {25'd0, bus.valid_out, bus.rdE_out, bus.rdIdx_out}, 32'd0);
    checkOutput("async reset rdData", bus.rdData_out, 32'd0);
    bus.valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    applyStimulus(4'd0, 32'h0000_ABCD, 32'h0, 5'd7, 1'b1, 32'h0000_ABCD);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycle();
      op   = 4'($urandom_range(0, 15));
      addr = $urandom;
      if ($urandom_range(0, 4) == 0) addr = 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
      exp  = (op >= 4'd1 && op <= 4'd5) ? refLoad(op, addr) : addr;
      applyStimulus(op, addr, $urandom, 5'($urandom), 1'($urandom), exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
